lane_controller: RTL and testbench



---
 rtl/lane_controller_if.sv | 20 ++
 rtl/lane_controller.sv | 149 ++++++++++++++
 tb/tb_lane_controller.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_controller_if.sv
// Tilt-in / lane-out signal bundle for lane_controller.
// The controller takes the slave modport; the debouncer/game side takes the master.
interface lane_controller_if;
    logic       btnL;
    logic       btnR;
    logic [1:0] lane;
    logic       move_pulse;
    logic       move_dir;
    logic       bump_pulse;

    modport master (
        output btnL, btnR,
        input  lane, move_pulse, move_dir, bump_pulse
    );

    modport slave (
        input  btnL, btnR,
        output lane, move_pulse, move_dir, bump_pulse
    );
endinterface

// File: rtl/lane_controller.sv
// Turns debounced btnL/btnR tilt levels into one lane move per gesture.
// Optional auto-repeat while a tilt is held: define AUTO_REPEAT_EN.
module lane_controller #(
    parameter int NUM_LANES     = 3,
    parameter int START_LANE    = 1,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_CYCLES = 50000000
) (
    input  logic              fast_hz,
    input  logic              rst,
    lane_controller_if.slave  bus
);
    typedef enum logic [1:0] {REQ_NONE, REQ_LEFT, REQ_RIGHT} req_t;
    typedef enum logic [1:0] {IDLE, HELD_L, HELD_R} state_t;

    localparam logic [1:0]  LP_LAST   = 2'(NUM_LANES - 1);
    localparam logic [1:0]  LP_START  = 2'(START_LANE);
    localparam logic [15:0] LP_STABLE = 16'(STABLE_CYCLES);

    if (NUM_LANES < 2 || NUM_LANES > 4 || START_LANE < 0 || START_LANE >= NUM_LANES ||
        STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 ||
        REPEAT_CYCLES < 1 || REPEAT_CYCLES > 67108863) begin : g_bad_params
        $error("lane_controller: parameter out of legal range");
    end

    req_t        w_raw;
    req_t        r_prev;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic        w_accept;
    state_t      r_state;
    state_t      w_state_next;
    logic        w_act;
    logic        w_act_right;
    logic [1:0]  r_lane;
    logic        r_move_pulse;
    logic        r_bump_pulse;
    logic        r_move_dir;

    always_comb begin
        w_raw = REQ_NONE;
        if (bus.btnL && !bus.btnR)
            w_raw = REQ_LEFT;
        else if (bus.btnR && !bus.btnL)
            w_raw = REQ_RIGHT;
    end

    // Acceptance is decided on the edge that takes the STABLE_CYCLES-th identical sample.
    always_comb begin
        if (w_raw != r_prev)
            w_cnt_next = 16'd1;
        else if (r_cnt == '1)
            w_cnt_next = r_cnt;
        else
            w_cnt_next = r_cnt + 16'd1;
        w_accept = (w_cnt_next == LP_STABLE);
    end

    always_ff @(posedge fast_hz or posedge rst) begin
        if (rst) begin
            r_prev <= REQ_NONE;
            r_cnt  <= '0;
        end else begin
            r_prev <= w_raw;
            r_cnt  <= w_cnt_next;
        end
    end

    always_ff @(posedge fast_hz or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (w_raw)
                REQ_LEFT:  w_state_next = HELD_L;
                REQ_RIGHT: w_state_next = HELD_R;
                default:   w_state_next = IDLE;
            endcase
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [25:0] LP_REP_LAST = 26'(REPEAT_CYCLES - 1);

    logic [25:0] r_rep;
    logic        w_rep_hit;

    assign w_rep_hit = (r_state != IDLE) && (w_state_next == r_state) &&
                       (r_rep == LP_REP_LAST);

    always_ff @(posedge fast_hz or posedge rst) begin
        if (rst)
            r_rep <= '0;
        else if (w_state_next != r_state || w_state_next == IDLE || w_rep_hit)
            r_rep <= '0;
        else
            r_rep <= r_rep + 26'd1;
    end
`endif

    always_comb begin
        w_act       = (w_state_next != r_state) && (w_state_next != IDLE);
        w_act_right = (w_state_next == HELD_R);
`ifdef AUTO_REPEAT_EN
        if (w_rep_hit)
            w_act = 1'b1;
`endif
    end

    always_ff @(posedge fast_hz or posedge rst) begin
        if (rst) begin
            r_lane       <= LP_START;
            r_move_pulse <= 1'b0;
            r_bump_pulse <= 1'b0;
            r_move_dir   <= 1'b0;
        end else begin
            r_move_pulse <= 1'b0;
            r_bump_pulse <= 1'b0;
            if (w_act) begin
                r_move_dir <= w_act_right;
                if (w_act_right) begin
                    if (r_lane != LP_LAST) begin
                        r_lane       <= r_lane + 2'd1;
                        r_move_pulse <= 1'b1;
                    end else begin
                        r_bump_pulse <= 1'b1;
                    end
                end else begin
                    if (r_lane != 2'd0) begin
                        r_lane       <= r_lane - 2'd1;
                        r_move_pulse <= 1'b1;
                    end else begin
                        r_bump_pulse <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.lane       = r_lane;
    assign bus.move_pulse = r_move_pulse;
    assign bus.bump_pulse = r_bump_pulse;
    assign bus.move_dir   = r_move_dir;
endmodule

// File: tb/tb_lane_controller.sv
// Scoreboard bench for lane_controller: each scenario queues the pulses it expects,
// a negedge monitor pops and compares them and tracks the expected lane every cycle.
module tb_lane_controller;
    localparam int NL = 3;
    localparam int SL = 1;
    localparam int SC = 4;
    localparam int RC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    lane_controller_if bus();

    lane_controller #(
        .NUM_LANES    (NL),
        .START_LANE   (SL),
        .STABLE_CYCLES(SC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .fast_hz(clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] lane;
        logic       dir;
        logic       bump;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc      = 0;
    int         checks   = 0;
    int         errors   = 0;
    logic [1:0] exp_lane = 2'(SL);

    always @(posedge clk) cyc = cyc + 1;

    function automatic void expect_ev(input int at, input logic [1:0] ln,
                                      input logic d, input logic b);
        ev_t e;
        e.cyc = at; e.lane = ln; e.dir = d; e.bump = b;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (bus.move_pulse === 1'b1 || bus.bump_pulse === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pulse cyc=%0d move=%b bump=%b lane=%0d, required no pulse",
                         cyc, bus.move_pulse, bus.bump_pulse, bus.lane);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.cyc || bus.lane !== e.lane || bus.move_dir !== e.dir ||
                    bus.bump_pulse !== e.bump || bus.move_pulse !== !e.bump) begin
                    errors = errors + 1;
                    $display("FAIL pulse_event got cyc=%0d lane=%0d dir=%b move=%b bump=%b, required cyc=%0d lane=%0d dir=%b move=%b bump=%b",
                             cyc, bus.lane, bus.move_dir, bus.move_pulse, bus.bump_pulse,
                             e.cyc, e.lane, e.dir, !e.bump, e.bump);
                end
                exp_lane = e.lane;
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            checks = checks + 1;
            errors = errors + 1;
            e = exp_q.pop_front();
            $display("FAIL missed_event no pulse at cyc=%0d, required pulse at cyc=%0d lane=%0d bump=%b",
                     cyc, e.cyc, e.lane, e.bump);
            exp_lane = e.lane;
        end
        checks = checks + 1;
        if (bus.lane !== exp_lane) begin
            errors = errors + 1;
            $display("FAIL lane_track cyc=%0d got lane=%0d, required %0d", cyc, bus.lane, exp_lane);
        end
    end

    task automatic hold(input logic l, input logic r, input int n);
        bus.btnL = l;
        bus.btnR = r;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btnL = 1'b0;
        bus.btnR = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if (bus.lane !== 2'(SL) || bus.move_pulse !== 1'b0 || bus.bump_pulse !== 1'b0 ||
            bus.move_dir !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_values got lane=%0d move=%b bump=%b dir=%b, required lane=%0d 0 0 0",
                     bus.lane, bus.move_pulse, bus.bump_pulse, bus.move_dir, SL);
        end
        rst = 1'b0;
        hold(1'b0, 1'b0, 8);
        checks = checks + 1;
        if (bus.lane !== 2'(SL) || bus.move_dir !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_idle got lane=%0d dir=%b, required lane=%0d dir=0",
                     bus.lane, bus.move_dir, SL);
        end
    endtask

    task automatic test_single_move();
        int c;
        c = cyc;
        expect_ev(c + SC, 2'd2, 1'b1, 1'b0);
`ifdef AUTO_REPEAT_EN
        expect_ev(c + SC + RC, 2'd2, 1'b1, 1'b1);
        expect_ev(c + SC + 2 * RC, 2'd2, 1'b1, 1'b1);
`endif
        hold(1'b0, 1'b1, 20);
        checks = checks + 1;
        if (bus.lane !== 2'd2 || bus.move_dir !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL single_move got lane=%0d dir=%b, required lane=2 dir=1", bus.lane, bus.move_dir);
        end
        hold(1'b0, 1'b0, 6);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL single_move_pending got %0d queued, required 0", exp_q.size());
        end
    endtask

    task automatic test_glitch_edge();
        int c;
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 6);
        checks = checks + 1;
        if (bus.lane !== 2'd2) begin
            errors = errors + 1;
            $display("FAIL glitch got lane=%0d, required 2", bus.lane);
        end
        c = cyc;
        expect_ev(c + SC, 2'd1, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 6);
        hold(1'b0, 1'b0, 6);
        c = cyc;
        expect_ev(c + SC, 2'd0, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 6);
        hold(1'b0, 1'b0, 6);
        c = cyc;
        expect_ev(c + SC, 2'd0, 1'b0, 1'b1);
`ifdef AUTO_REPEAT_EN
        expect_ev(c + SC + RC, 2'd0, 1'b0, 1'b1);
`endif
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 6);
        checks = checks + 1;
        if (bus.lane !== 2'd0 || bus.move_dir !== 1'b0 || exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL edge_bump got lane=%0d dir=%b queued=%0d, required lane=0 dir=0 queued=0",
                     bus.lane, bus.move_dir, exp_q.size());
        end
    endtask

    task automatic test_reversal_conflict();
        int c;
        c = cyc;
        expect_ev(c + SC, 2'd1, 1'b1, 1'b0);
        hold(1'b0, 1'b1, 6);
        c = cyc;
        expect_ev(c + SC, 2'd0, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 6);
        hold(1'b0, 1'b0, 6);
        checks = checks + 1;
        if (bus.lane !== 2'd0 || bus.move_dir !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reversal got lane=%0d dir=%b, required lane=0 dir=0", bus.lane, bus.move_dir);
        end
        c = cyc;
        expect_ev(c + SC, 2'd1, 1'b1, 1'b0);
        hold(1'b0, 1'b1, 6);
        hold(1'b1, 1'b1, 10);
        // A fresh right move is only taken from IDLE, proving the conflict dropped HELD_R.
        c = cyc;
        expect_ev(c + SC, 2'd2, 1'b1, 1'b0);
        hold(1'b0, 1'b1, 6);
        hold(1'b0, 1'b0, 6);
        checks = checks + 1;
        if (bus.lane !== 2'd2 || exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL conflict got lane=%0d queued=%0d, required lane=2 queued=0",
                     bus.lane, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        int c;
        c = cyc;
        expect_ev(c + SC, 2'd2, 1'b1, 1'b1);
        hold(1'b0, 1'b1, 6);
        #2;
        rst = 1'b1;
        exp_lane = 2'(SL);
        #1;
        checks = checks + 1;
        if (bus.lane !== 2'(SL) || bus.move_pulse !== 1'b0 || bus.bump_pulse !== 1'b0 ||
            bus.move_dir !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL async_reset got lane=%0d move=%b bump=%b dir=%b, required lane=%0d 0 0 0",
                     bus.lane, bus.move_pulse, bus.bump_pulse, bus.move_dir, SL);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        c = cyc;
        expect_ev(c + SC, 2'd2, 1'b1, 1'b0);
        hold(1'b0, 1'b1, 6);
        hold(1'b0, 1'b0, 6);
        checks = checks + 1;
        if (bus.lane !== 2'd2 || exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL after_reset got lane=%0d queued=%0d, required lane=2 queued=0",
                     bus.lane, exp_q.size());
        end
    endtask

    task automatic test_hold_repeat();
        int c;
        logic [1:0] final_lane;
        c = cyc;
        expect_ev(c + SC, 2'd1, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 6);
        hold(1'b0, 1'b0, 6);
        c = cyc;
        expect_ev(c + SC, 2'd0, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 6);
        hold(1'b0, 1'b0, 6);
        c = cyc;
        expect_ev(c + SC, 2'd1, 1'b1, 1'b0);
`ifdef AUTO_REPEAT_EN
        expect_ev(c + SC + RC,     2'd2, 1'b1, 1'b0);
        expect_ev(c + SC + 2 * RC, 2'd2, 1'b1, 1'b1);
        expect_ev(c + SC + 3 * RC, 2'd2, 1'b1, 1'b1);
        expect_ev(c + SC + 4 * RC, 2'd2, 1'b1, 1'b1);
        final_lane = 2'd2;
`else
        final_lane = 2'd1;
`endif
        hold(1'b0, 1'b1, 40);
        hold(1'b0, 1'b0, 6);
        checks = checks + 1;
        if (bus.lane !== final_lane || exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL long_hold got lane=%0d queued=%0d, required lane=%0d queued=0",
                     bus.lane, exp_q.size(), final_lane);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btnL = 1'b0;
        bus.btnR = 1'b0;
        test_reset();
        test_single_move();
        test_glitch_edge();
        test_reversal_conflict();
        test_async_reset();
        test_hold_repeat();
        hold(1'b0, 1'b0, 4);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL leftover_events got %0d queued, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
